// File: rtl/fcast_sched_if.sv
// Bundles the requester issue ports, the result port and the fcast unit handshake of fcast_sched.
// slave is the scheduler's view; master is the view of the surrounding requesters, consumer and unit.
interface fcast_sched_if #(
    parameter int NREQ           = 4,
    parameter int OPERAND_WIDTH  = 32,
    parameter int EXPONENT_WIDTH = 8,
    parameter int FRACTION_WIDTH = 23
);
    localparam int ID_WIDTH = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]               req_valid_i;
    logic [NREQ*OPERAND_WIDTH-1:0] req_op_i;
    logic [NREQ-1:0]               req_ready_o;

    logic                          res_valid_o;
    logic                          res_ready_i;
    logic [OPERAND_WIDTH-1:0]      res_data_o;
    logic [ID_WIDTH-1:0]           res_id_o;
    logic                          res_inexact_o;
    logic                          busy_o;

    logic                          fcast_en_o;
    logic [OPERAND_WIDTH-1:0]      fcast_op_o;
    logic                          fcast_sign_i;
    logic [EXPONENT_WIDTH-1:0]     fcast_exp_i;
    logic [FRACTION_WIDTH-1:0]     fcast_frac_i;
    logic [2:0]                    fcast_grs_bit_i;
    logic                          fcast_ready_i;

    modport slave (
        input  req_valid_i, req_op_i, res_ready_i,
        input  fcast_sign_i, fcast_exp_i, fcast_frac_i, fcast_grs_bit_i, fcast_ready_i,
        output req_ready_o, res_valid_o, res_data_o, res_id_o, res_inexact_o, busy_o,
        output fcast_en_o, fcast_op_o
    );

    modport master (
        output req_valid_i, req_op_i, res_ready_i,
        output fcast_sign_i, fcast_exp_i, fcast_frac_i, fcast_grs_bit_i, fcast_ready_i,
        input  req_ready_o, res_valid_o, res_data_o, res_id_o, res_inexact_o, busy_o,
        input  fcast_en_o, fcast_op_o
    );
endinterface

// File: rtl/fcast_sched.sv
// Round-robin scheduler sharing one int32->fp32 fcast unit among NREQ requesters.
// Rounds the unit's truncated result to nearest-even; zero and the most negative int bypass the unit.
module fcast_sched #(
    parameter int NREQ           = 4,
    parameter int OPERAND_WIDTH  = 32,
    parameter int EXPONENT_WIDTH = 8,
    parameter int FRACTION_WIDTH = 23
) (
    input logic         fpu_clk,
    input logic         fpu_rst,
    fcast_sched_if.slave bus
);
    localparam int ID_WIDTH = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int EF_WIDTH = EXPONENT_WIDTH + FRACTION_WIDTH;
    localparam int BIAS     = (1 << (EXPONENT_WIDTH - 1)) - 1;
    localparam int R_POS    = OPERAND_WIDTH - FRACTION_WIDTH - 2;

    localparam logic [OPERAND_WIDTH-1:0]  MIN_INT    = {1'b1, {(OPERAND_WIDTH-1){1'b0}}};
    localparam logic [OPERAND_WIDTH-1:0]  MIN_INT_FP =
        {1'b1, EXPONENT_WIDTH'(BIAS + OPERAND_WIDTH - 1), {FRACTION_WIDTH{1'b0}}};
    localparam logic [EXPONENT_WIDTH-1:0] SHIFT_BASE = EXPONENT_WIDTH'(BIAS + OPERAND_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RND,
        RESP
    } state_t;

    state_t                    state_q, state_d;
    logic [ID_WIDTH-1:0]       ptr_q;
    logic [OPERAND_WIDTH-1:0]  op_q;
    logic [ID_WIDTH-1:0]       id_q;
    logic                      sign_q;
    logic [EXPONENT_WIDTH-1:0] exp_q;
    logic [FRACTION_WIDTH-1:0] frac_q;
    logic [1:0]                grs_q;
    logic [OPERAND_WIDTH-1:0]  res_q;
    logic                      inexact_q;

    logic                      grant_found;
    logic [ID_WIDTH-1:0]       grant_id;
    logic [ID_WIDTH:0]         cand;
    logic [ID_WIDTH-1:0]       next_ptr;
    logic [OPERAND_WIDTH-1:0]  sel_op;
    logic [NREQ-1:0]           req_ready;
    logic                      fcast_en;
    logic                      res_valid;

    logic [OPERAND_WIDTH-1:0]  mag;
    logic [EXPONENT_WIDTH-1:0] shamt;
    logic [R_POS-1:0]          sticky_bits;
    logic                      sticky;
    logic                      inc;
    logic [EF_WIDTH-1:0]       rounded;

    // Search starts at the pointer and wraps, so the last winner has lowest priority next time.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
            if (cand >= (ID_WIDTH+1)'(NREQ)) begin
                cand = cand - (ID_WIDTH+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid_i[cand[ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                sel_op = bus.req_op_i[i*OPERAND_WIDTH +: OPERAND_WIDTH];
            end
        end
    end

    assign next_ptr = (grant_id == ID_WIDTH'(NREQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);

    always_ff @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        fcast_en  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    state_d = ((sel_op == '0) || (sel_op == MIN_INT)) ? RESP : EXEC;
                end
            end
            EXEC: begin
                fcast_en = 1'b1;
                if (bus.fcast_ready_i) begin
                    state_d = RND;
                end
            end
            RND: begin
                state_d = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky covers the magnitude bits the unit drops below its round bit.
    assign mag         = op_q[OPERAND_WIDTH-1] ? (~op_q + OPERAND_WIDTH'(1)) : op_q;
    assign shamt       = SHIFT_BASE - exp_q;
    assign sticky_bits = R_POS'(mag << shamt);
    assign sticky      = |sticky_bits;
    assign inc         = grs_q[1] & (grs_q[0] | sticky | frac_q[0]);
    assign rounded     = {exp_q, frac_q} + EF_WIDTH'(inc);

    always_ff @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst) begin
            ptr_q     <= '0;
            op_q      <= '0;
            id_q      <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            frac_q    <= '0;
            grs_q     <= '0;
            res_q     <= '0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        op_q  <= sel_op;
                        id_q  <= grant_id;
                        ptr_q <= next_ptr;
                        if (sel_op == '0) begin
                            res_q     <= '0;
                            inexact_q <= 1'b0;
                        end else if (sel_op == MIN_INT) begin
                            res_q     <= MIN_INT_FP;
                            inexact_q <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    if (bus.fcast_ready_i) begin
                        sign_q <= bus.fcast_sign_i;
                        exp_q  <= bus.fcast_exp_i;
                        frac_q <= bus.fcast_frac_i;
                        grs_q  <= bus.fcast_grs_bit_i[1:0];
                    end
                end
                RND: begin
                    res_q     <= {sign_q, rounded};
                    inexact_q <= grs_q[1] | grs_q[0] | sticky;
                end
                default: ;
            endcase
        end
    end

    // Accept pulses are suppressed while reset is held so every output reads zero.
    assign bus.req_ready_o   = fpu_rst ? '0 : req_ready;
    assign bus.res_valid_o   = res_valid;
    assign bus.res_data_o    = res_q;
    assign bus.res_id_o      = id_q;
    assign bus.res_inexact_o = inexact_q;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.fcast_en_o    = fcast_en;
    assign bus.fcast_op_o    = op_q;
endmodule

// File: tb/tb_fcast_sched.sv
// Directed bench for fcast_sched with a behavioural fcast unit that answers in its third enabled cycle.
// Expected results are hand-computed fp32 encodings; the unit model only supplies truncated fields.
module tb_fcast_sched;
    localparam int NREQ = 4;

    logic fpu_clk = 1'b0;
    logic fpu_rst = 1'b1;
    int   total   = 0;
    int   passed  = 0;
    int   failed  = 0;
    int   en_cnt;
    logic grant_seen;

    fcast_sched_if #(.NREQ(NREQ)) bus ();

    fcast_sched #(.NREQ(NREQ)) dut (
        .fpu_clk (fpu_clk),
        .fpu_rst (fpu_rst),
        .bus     (bus)
    );

    always #5 fpu_clk = ~fpu_clk;

    // Unit model: result fields from the normalised magnitude, valid in the third enabled cycle.
    function automatic logic [34:0] fcast_model(input logic [31:0] op);
        logic [31:0] mag;
        logic [31:0] sh;
        int          p;
        mag = op[31] ? (~op + 32'd1) : op;
        p   = 0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) p = i;
        end
        sh = mag << (32 - p);
        return {op[31], 8'(127 + p), sh[31:9], sh[9:7]};
    endfunction

    always @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst) begin
            en_cnt <= 0;
        end else if (!bus.fcast_en_o) begin
            en_cnt <= 0;
        end else if (en_cnt < 3) begin
            en_cnt <= en_cnt + 1;
        end
    end

    assign {bus.fcast_sign_i, bus.fcast_exp_i, bus.fcast_frac_i, bus.fcast_grs_bit_i} =
        fcast_model(bus.fcast_op_o);
    assign bus.fcast_ready_i = bus.fcast_en_o && (en_cnt >= 2);

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int k, input logic [31:0] op);
        bus.req_valid_i[k]        = 1'b1;
        bus.req_op_i[k*32 +: 32]  = op;
    endtask

    // Called just after a rising edge with requests already driven; ends just after the handshake edge.
    task automatic run_txn(input string tag, input int exp_id, input logic [31:0] exp_data,
                           input logic exp_inexact, input int exp_lat, input int hold,
                           input logic keep);
        logic       found;
        logic [3:0] ready_seen;
        int         lat;
        logic       stable_ok;
        logic       no_grant_ok;
        logic       en_low_ok;

        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge fpu_clk);
            if (bus.req_ready_o != '0) found = 1'b1;
            else @(posedge fpu_clk);
        end
        ready_seen = bus.req_ready_o;
        check_output({tag, "_grant"}, 32'(ready_seen), 32'(4'b0001 << exp_id));

        @(posedge fpu_clk);
        #1;
        if (!keep) bus.req_valid_i = '0;

        lat   = 1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge fpu_clk);
            if (bus.res_valid_o) found = 1'b1;
            else begin
                @(posedge fpu_clk);
                lat++;
            end
        end
        check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "_data"}, bus.res_data_o, exp_data);
        check_output({tag, "_id"}, 32'(bus.res_id_o), 32'(exp_id));
        check_output({tag, "_inexact"}, 32'(bus.res_inexact_o), 32'(exp_inexact));

        stable_ok   = 1'b1;
        no_grant_ok = 1'b1;
        en_low_ok   = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge fpu_clk);
            if (bus.res_data_o !== exp_data || bus.res_id_o !== 2'(exp_id) ||
                bus.res_valid_o !== 1'b1) stable_ok = 1'b0;
            if (bus.req_ready_o !== '0) no_grant_ok = 1'b0;
            if (bus.fcast_en_o !== 1'b0) en_low_ok = 1'b0;
        end
        if (hold > 0) begin
            check_output({tag, "_hold_stable"}, 32'(stable_ok), 32'd1);
            check_output({tag, "_hold_no_grant"}, 32'(no_grant_ok), 32'd1);
            check_output({tag, "_hold_en_low"}, 32'(en_low_ok), 32'd1);
        end

        bus.res_ready_i = 1'b1;
        @(posedge fpu_clk);
        #1;
        bus.res_ready_i = 1'b0;
        check_output({tag, "_idle_after"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_op_i    = '0;
        bus.res_ready_i = 1'b0;
        fpu_rst         = 1'b1;

        #1;
        $display("[TB] reset state");
        check_output("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
        check_output("rst_res_data", bus.res_data_o, 32'h0000_0000);
        check_output("rst_busy", 32'(bus.busy_o), 32'd0);
        check_output("rst_fcast_en", 32'(bus.fcast_en_o), 32'd0);
        check_output("rst_fcast_op", bus.fcast_op_o, 32'h0000_0000);

        repeat (2) @(posedge fpu_clk);
        #1;
        fpu_rst = 1'b0;
        @(posedge fpu_clk);
        #1;

        $display("[TB] basic conversions");
        apply_stimulus(0, 32'h0000_0001);
        run_txn("t1_one", 0, 32'h3F80_0000, 1'b0, 5, 0, 1'b0);
        apply_stimulus(2, 32'hFFFF_FFFB);
        run_txn("t2_neg5", 2, 32'hC0A0_0000, 1'b0, 5, 0, 1'b0);
        apply_stimulus(2, 32'h0000_0000);
        run_txn("t2_zero", 2, 32'h0000_0000, 1'b0, 1, 0, 1'b0);

        $display("[TB] rounding");
        apply_stimulus(1, 32'h0100_0001);
        run_txn("t3_tie_even", 1, 32'h4B80_0000, 1'b1, 5, 0, 1'b0);
        apply_stimulus(3, 32'h0100_0003);
        run_txn("t3_tie_odd", 3, 32'h4B80_0002, 1'b1, 5, 0, 1'b0);
        apply_stimulus(1, 32'h8000_0000);
        run_txn("t4_min_int", 1, 32'hCF00_0000, 1'b0, 1, 0, 1'b0);
        apply_stimulus(3, 32'h7FFF_FFFF);
        run_txn("t4_max_int", 3, 32'h4F00_0000, 1'b1, 5, 0, 1'b0);

        $display("[TB] round-robin with all requesters valid");
        apply_stimulus(0, 32'h0000_0001);
        apply_stimulus(1, 32'hFFFF_FFFB);
        apply_stimulus(2, 32'h0100_0001);
        apply_stimulus(3, 32'h0000_0000);
        run_txn("t5_g0", 0, 32'h3F80_0000, 1'b0, 5, 10, 1'b1);
        run_txn("t5_g1", 1, 32'hC0A0_0000, 1'b0, 5, 0, 1'b1);
        run_txn("t5_g2", 2, 32'h4B80_0000, 1'b1, 5, 0, 1'b1);
        run_txn("t5_g3", 3, 32'h0000_0000, 1'b0, 1, 0, 1'b1);
        run_txn("t5_g4", 0, 32'h3F80_0000, 1'b0, 5, 0, 1'b0);

        $display("[TB] reset during execution");
        apply_stimulus(2, 32'h7FFF_FFFF);
        grant_seen = 1'b0;
        for (int c = 0; c < 20 && !grant_seen; c++) begin
            @(negedge fpu_clk);
            if (bus.req_ready_o != '0) grant_seen = 1'b1;
            else @(posedge fpu_clk);
        end
        check_output("t6_grant", 32'(bus.req_ready_o), 32'h0000_0004);
        @(posedge fpu_clk);
        #1;
        bus.req_valid_i = '0;
        @(negedge fpu_clk);
        check_output("t6_exec_en", 32'(bus.fcast_en_o), 32'd1);
        #1;
        fpu_rst = 1'b1;
        #1;
        check_output("t6_rst_en", 32'(bus.fcast_en_o), 32'd0);
        check_output("t6_rst_busy", 32'(bus.busy_o), 32'd0);
        check_output("t6_rst_fcast_op", bus.fcast_op_o, 32'h0000_0000);
        check_output("t6_rst_res_data", bus.res_data_o, 32'h0000_0000);
        check_output("t6_rst_res_id", 32'(bus.res_id_o), 32'd0);
        check_output("t6_rst_res_valid", 32'(bus.res_valid_o), 32'd0);
        @(posedge fpu_clk);
        #1;
        fpu_rst = 1'b0;
        // Pointer back at 0 means requester 1 wins over requester 3.
        apply_stimulus(1, 32'h0000_0001);
        apply_stimulus(3, 32'h0000_0000);
        run_txn("t6_after", 1, 32'h3F80_0000, 1'b0, 5, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
